// File: rtl/timer_counter.sv
// 64-bit free-running timer with software-writable counter and compare,
// disable-clear on timer_en falling edge, and a sticky maskable interrupt.
module timer_counter #(
    parameter logic [63:0] CMP_INIT = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cnt_en,
    input  logic        timer_en,
    input  logic        cnt_wr_lo,
    input  logic        cnt_wr_hi,
    input  logic        cmp_wr_lo,
    input  logic        cmp_wr_hi,
    input  logic [31:0] wdata,
    input  logic        int_en,
    input  logic        int_clr,
    output logic [63:0] cnt_val,
    output logic [63:0] cmp_val,
    output logic        int_st,
    output logic        tim_int
);

    logic [63:0] cnt;
    logic [63:0] cmp;
    logic        ten_q;
    logic        st;
    logic        cnt_wr;
    logic        dis_clr;
    logic        inc;
    logic        match;

    assign cnt_wr  = cnt_wr_lo | cnt_wr_hi;
    assign dis_clr = ten_q & ~timer_en;
    assign inc     = cnt_en & timer_en;
    assign match   = (cnt == cmp);

    // Previous timer_en, used to spot the enable falling edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ten_q <= 1'b0;
        end else begin
            ten_q <= timer_en;
        end
    end

    // Counter: write beats disable-clear, which beats increment.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt <= 64'd0;
        end else if (cnt_wr) begin
            if (cnt_wr_lo) begin
                cnt[31:0] <= wdata;
            end
            if (cnt_wr_hi) begin
                cnt[63:32] <= wdata;
            end
        end else if (dis_clr) begin
            cnt <= 64'd0;
        end else if (inc) begin
            cnt <= cnt + 64'd1;
        end
    end

    // Compare register, written in halves independently of the counter.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cmp <= CMP_INIT;
        end else begin
            if (cmp_wr_lo) begin
                cmp[31:0] <= wdata;
            end
            if (cmp_wr_hi) begin
                cmp[63:32] <= wdata;
            end
        end
    end

    // Sticky status: a match sets it and overrides a same-cycle clear.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            st <= 1'b0;
        end else if (match) begin
            st <= 1'b1;
        end else if (int_clr) begin
            st <= 1'b0;
        end
    end

    assign cnt_val = cnt;
    assign cmp_val = cmp;
    assign int_st  = st;
    assign tim_int = st & int_en;

endmodule
